// File: rtl/dm_wb_cache_if.sv
// ============================================================================
// Module   : dm_wb_cache_if
// Brief    : Core-side word bus plus memory-side 256-bit line bus for dm_wb_cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_wb_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  // The cache side: serves the core, issues line traffic to memory.
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // The environment side: core requester plus line memory.
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

`default_nettype wire

// File: rtl/dm_wb_cache.sv
// ============================================================================
// Module   : dm_wb_cache
// Brief    : Direct-mapped, write-back, write-allocate cache with 32-byte lines.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_wb_cache #(
  parameter int S_INDEX = 3
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dm_wb_cache_if.slave  bus
);

  localparam int TAG_W  = 32 - 5 - S_INDEX;
  localparam int NLINES = 2 ** S_INDEX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    WB    = 2'd2,
    ALLOC = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NLINES-1:0]      valid_q;
  logic [NLINES-1:0]      dirty_q;
  logic [TAG_W-1:0]       tag_q  [NLINES];
  logic [255:0]           data_q [NLINES];
  logic [31:0]            rdata_q;

  logic [S_INDEX-1:0]     w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [2:0]             w_word;
  logic                   w_req;
  logic                   w_is_wr;
  logic                   w_hit;
  logic [255:0]           w_line_rd;
  logic [31:0]            w_word_rd;
  logic [31:0]            w_word_wr;
  logic [255:0]           w_line_wr;
  logic                   w_load_rdata;
  logic                   w_do_write;
  logic                   w_wb_done;
  logic                   w_fill_done;
  logic                   w_unused;

  assign w_idx     = bus.mem_address[5+S_INDEX-1:5];
  assign w_tag     = bus.mem_address[31 -: TAG_W];
  assign w_word    = bus.mem_address[4:2];
  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_is_wr   = bus.mem_write;
  assign w_hit     = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_line_rd = data_q[w_idx];
  assign w_unused  = ^bus.mem_address[1:0];

  always_comb begin
    w_word_rd = w_line_rd[{w_word, 5'b0} +: 32];
    w_word_wr = w_word_rd;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_enable[b]) w_word_wr[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
    w_line_wr = w_line_rd;
    w_line_wr[{w_word, 5'b0} +: 32] = w_word_wr;
  end

  always_comb begin
    state_d          = state_q;
    w_load_rdata     = 1'b0;
    w_do_write       = 1'b0;
    w_wb_done        = 1'b0;
    w_fill_done      = 1'b0;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            state_d      = RESP;
            w_do_write   = w_is_wr;
            w_load_rdata = ~w_is_wr;
          end else if (valid_q[w_idx] && dirty_q[w_idx]) begin
            state_d = WB;
          end else begin
            state_d = ALLOC;
          end
        end
      end
      RESP: begin
        bus.mem_resp = 1'b1;
        state_d      = IDLE;
      end
      WB: begin
        // Request is held by the core, so w_idx still names the victim line.
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[w_idx], w_idx, 5'b0};
        bus.pmem_wdata   = w_line_rd;
        if (bus.pmem_resp) begin
          w_wb_done = 1'b1;
          state_d   = ALLOC;
        end
      end
      ALLOC: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.mem_address[31:5], 5'b0};
        if (bus.pmem_resp) begin
          w_fill_done = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_load_rdata) rdata_q <= w_word_rd;
      if (w_do_write)   dirty_q[w_idx] <= 1'b1;
      if (w_wb_done)    dirty_q[w_idx] <= 1'b0;
      if (w_fill_done) begin
        valid_q[w_idx] <= 1'b1;
        dirty_q[w_idx] <= 1'b0;
      end
    end
  end

  // Tag and data contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_do_write) data_q[w_idx] <= w_line_wr;
      if (w_fill_done) begin
        data_q[w_idx] <= bus.pmem_rdata;
        tag_q[w_idx]  <= w_tag;
      end
    end
  end

  assign bus.mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_wb_cache.sv
// ============================================================================
// Module   : tb_dm_wb_cache
// Brief    : Directed self-checking bench for dm_wb_cache with a line-memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_wb_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_wb_cache_if bus();

  dm_wb_cache #(.S_INDEX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Backing memory (line granular) and the architectural word view seen by the core.
  logic [255:0] bmem  [int unsigned];
  logic [31:0]  truth [int unsigned];

  // Cache residency model: which line each set holds and whether it was written.
  bit          mvalid [8];
  bit          mdirty [8];
  logic [23:0] mtag   [8];

  int           lat = 0;
  int           stray_cnt = 0;
  int           stray_done = 0;
  int           rcnt = 0;
  int           n_wb = 0, n_fill = 0, ev_seq = 0;
  int           wb_seq = 0, fill_seq = 0;
  logic [31:0]  last_wb_addr = '0, last_fill_addr = '0;
  logic [255:0] last_wb_data = '0;
  int           resp_seen = 0;
  bit           outstanding = 0, exp_rd_valid = 0, run_cmp = 0;
  logic [31:0]  exp_rdata = '0;

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'(w) * 32'h01010101) ^ 32'hA5A50000;
    if (la == 32'h0000_0100) l[63:32] = 32'hDEADBEEF;
    return l;
  endfunction

  function automatic logic [255:0] back_line(input logic [31:0] la);
    if (bmem.exists(la)) return bmem[la];
    return init_line(la);
  endfunction

  function automatic logic [31:0] truth_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (truth.exists(wa)) return truth[wa];
    l = back_line({a[31:5], 5'b0});
    return l[{a[4:2], 5'b0} +: 32];
  endfunction

  function automatic logic [255:0] truth_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = truth_word(la + 32'(4*w));
    return l;
  endfunction

  // Line memory: answers a held strobe after lat idle cycles with a one-cycle pmem_resp.
  always @(negedge clk) begin
    if (bus.pmem_resp === 1'b1) begin
      bus.pmem_resp = 1'b0;
      rcnt = 0;
    end else if (bus.pmem_write === 1'b1) begin
      if (rcnt >= lat) begin
        chk(bus.pmem_wdata == truth_line(bus.pmem_address), "wb_data", bus.pmem_wdata, truth_line(bus.pmem_address));
        bmem[bus.pmem_address] = bus.pmem_wdata;
        last_wb_addr = bus.pmem_address;
        last_wb_data = bus.pmem_wdata;
        n_wb++; ev_seq++; wb_seq = ev_seq;
        bus.pmem_resp = 1'b1;
      end else rcnt++;
    end else if (bus.pmem_read === 1'b1) begin
      if (rcnt >= lat) begin
        bus.pmem_rdata = back_line(bus.pmem_address);
        last_fill_addr = bus.pmem_address;
        n_fill++; ev_seq++; fill_seq = ev_seq;
        bus.pmem_resp = 1'b1;
      end else rcnt++;
    end else begin
      rcnt = 0;
      bus.pmem_resp = 1'b0;
      if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        bus.pmem_resp = 1'b1;
      end
    end
  end

  logic resp_at_pos = 1'b0;
  always @(posedge clk) resp_at_pos <= bus.pmem_resp;

  // Per-cycle compare against the bus rules and the expected read value.
  logic         prev_pr = 1'b0, prev_pw = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [255:0] prev_wdata = '0;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk(!(bus.pmem_read && bus.pmem_write), "strobe_excl", {bus.pmem_read, bus.pmem_write}, 2'b00);
      if (bus.pmem_read || bus.pmem_write)
        chk(bus.pmem_address[4:0] == 5'd0, "pmem_addr_align", bus.pmem_address, {bus.pmem_address[31:5], 5'b0});
      if (((bus.pmem_read && prev_pr) || (bus.pmem_write && prev_pw)) && !resp_at_pos)
        chk(bus.pmem_address == prev_addr && bus.pmem_wdata == prev_wdata, "pmem_hold", bus.pmem_address, prev_addr);
      if (bus.mem_resp) begin
        resp_seen++;
        chk(outstanding, "unexpected_resp", 1, 0);
        if (exp_rd_valid) chk(bus.mem_rdata == exp_rdata, "rdata", bus.mem_rdata, exp_rdata);
      end
    end
    prev_pr    = bus.pmem_read;
    prev_pw    = bus.pmem_write;
    prev_addr  = bus.pmem_address;
    prev_wdata = bus.pmem_wdata;
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input string nm, output logic [31:0] rd);
    logic [2:0]  idx;
    logic [23:0] tg;
    bit          exp_fill, exp_wb, got;
    logic [31:0] wb_a, old, nw;
    int          wb0, f0, r0, cyc;
    idx = a[7:5];
    tg  = a[31:8];
    exp_fill = !(mvalid[idx] && mtag[idx] == tg);
    exp_wb   = exp_fill && mvalid[idx] && mdirty[idx];
    wb_a     = {mtag[idx], idx, 5'b0};
    wb0 = n_wb; f0 = n_fill; r0 = resp_seen;
    exp_rdata    = truth_word(a);
    exp_rd_valid = !wr;
    outstanding  = 1'b1;
    bus.mem_read = !wr; bus.mem_write = wr; bus.mem_address = a;
    bus.mem_wdata = wd; bus.mem_byte_enable = be;
    cyc = 0; got = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_resp) got = 1;
    end
    rd = bus.mem_rdata;
    chk(got, {nm, "_resp_timeout"}, got, 1);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk);
    chk(!bus.mem_resp, {nm, "_resp_single"}, bus.mem_resp, 0);
    outstanding = 1'b0; exp_rd_valid = 1'b0;
    chk(resp_seen - r0 == 1, {nm, "_resp_count"}, resp_seen - r0, 1);
    chk((n_wb - wb0) == int'(exp_wb), {nm, "_wb_count"}, n_wb - wb0, exp_wb);
    chk((n_fill - f0) == int'(exp_fill), {nm, "_fill_count"}, n_fill - f0, exp_fill);
    if (exp_wb && n_wb != wb0) chk(last_wb_addr == wb_a, {nm, "_wb_addr"}, last_wb_addr, wb_a);
    if (exp_fill && n_fill != f0) chk(last_fill_addr == {a[31:5], 5'b0}, {nm, "_fill_addr"}, last_fill_addr, {a[31:5], 5'b0});
    if (exp_wb && exp_fill) chk(wb_seq < fill_seq, {nm, "_wb_before_fill"}, wb_seq, fill_seq);
    if (!exp_fill) chk(cyc == 1, {nm, "_hit_latency"}, cyc, 1);
    if (exp_fill) begin mvalid[idx] = 1; mtag[idx] = tg; mdirty[idx] = 0; end
    if (wr) begin
      mdirty[idx] = 1;
      old = truth_word(a);
      nw  = old;
      for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wd[8*b +: 8];
      truth[{a[31:2], 2'b00}] = nw;
    end
  endtask

  // Reset discards dirty lines: the core-visible view falls back to backing memory.
  task automatic model_reset();
    logic [31:0] la;
    for (int s = 0; s < 8; s++) begin
      if (mvalid[s] && mdirty[s]) begin
        la = {mtag[s], 3'(s), 5'b0};
        for (int w = 0; w < 8; w++) if (truth.exists(la + 32'(4*w))) truth.delete(la + 32'(4*w));
      end
      mvalid[s] = 0; mdirty[s] = 0;
    end
  endtask

  initial begin
    logic [31:0]  rd;
    logic [255:0] l;
    bit           seen;
    rst = 1'b1;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_byte_enable = 0;
    bus.mem_address = 0; bus.mem_wdata = 0;
    for (int s = 0; s < 8; s++) begin mvalid[s] = 0; mdirty[s] = 0; mtag[s] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmp = 1;
    chk(bus.mem_resp == 0,     "rst_mem_resp",   bus.mem_resp, 0);
    chk(bus.pmem_read == 0,    "rst_pmem_read",  bus.pmem_read, 0);
    chk(bus.pmem_write == 0,   "rst_pmem_write", bus.pmem_write, 0);
    chk(bus.mem_rdata == 0,    "rst_mem_rdata",  bus.mem_rdata, 0);
    chk(bus.pmem_address == 0, "rst_pmem_addr",  bus.pmem_address, 0);
    chk(bus.pmem_wdata == 0,   "rst_pmem_wdata", bus.pmem_wdata, 0);

    access(0, 32'h0000_0104, 0, 0, "cold_rd", rd);
    chk(rd == 32'hDEADBEEF, "cold_rd_lit", rd, 32'hDEADBEEF);
    chk(last_fill_addr == 32'h0000_0100, "cold_fill_lit", last_fill_addr, 32'h100);
    chk(n_wb == 0, "cold_no_wb", n_wb, 0);
    access(0, 32'h0000_0104, 0, 0, "hit_rd", rd);
    access(1, 32'h0000_0104, 32'h11223344, 4'b0101, "hit_wr", rd);
    access(0, 32'h0000_0104, 0, 0, "merge_rd", rd);
    chk(rd == 32'hDE22BE44, "merge_rd_lit", rd, 32'hDE22BE44);
    access(0, 32'h0000_0504, 0, 0, "evict_rd", rd);
    l = last_wb_data;
    chk(last_wb_addr == 32'h0000_0100, "evict_wb_addr_lit", last_wb_addr, 32'h100);
    chk(l[63:32] == 32'hDE22BE44, "evict_wb_word_lit", l[63:32], 32'hDE22BE44);
    chk(last_fill_addr == 32'h0000_0500, "evict_fill_lit", last_fill_addr, 32'h500);

    access(1, 32'h0000_0508, 32'hCAFEF00D, 4'b1111, "dirty_wr", rd);
    lat = 10;
    access(0, 32'h0000_0904, 0, 0, "slow_evict", rd);
    lat = 0;
    access(1, 32'h0000_002C, 32'hABCD0000, 4'b1100, "wr_alloc", rd);
    access(1, 32'h0000_002C, 32'hFFFFFFFF, 4'b0000, "wr_be0", rd);
    access(0, 32'h0000_002C, 0, 0, "rd_after_wr", rd);
    access(1, 32'hFFFF_FFFC, 32'h55AA55AA, 4'b1111, "wrap_wr", rd);
    access(0, 32'hFFFF_FFE0, 0, 0, "wrap_rd", rd);
    access(0, 32'h0000_00FC, 0, 0, "wrap_evict", rd);
    chk(last_wb_addr == 32'hFFFF_FFE0, "wrap_wb_addr_lit", last_wb_addr, 32'hFFFFFFE0);

    stray_cnt++;
    repeat (4) begin
      @(negedge clk);
      chk(!bus.pmem_read && !bus.pmem_write && !bus.mem_resp, "stray_idle", {bus.pmem_read, bus.pmem_write, bus.mem_resp}, 0);
    end
    access(0, 32'h0000_00FC, 0, 0, "post_stray_hit", rd);
    access(1, 32'h0000_0904, 32'h0BADF00D, 4'b1111, "pre_rst_wr", rd);

    // Reset while the fill for 0x504 is pending.
    lat = 10;
    outstanding = 1'b1;
    bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0504; bus.mem_byte_enable = 0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.pmem_read) seen = 1;
    end
    chk(seen, "reach_alloc", seen, 1);
    rst = 1'b1; bus.mem_read = 1'b0; outstanding = 1'b0;
    @(negedge clk);
    chk(bus.pmem_read == 0,  "rst_mid_pmem_read",  bus.pmem_read, 0);
    chk(bus.pmem_write == 0, "rst_mid_pmem_write", bus.pmem_write, 0);
    chk(bus.mem_resp == 0,   "rst_mid_mem_resp",   bus.mem_resp, 0);
    chk(bus.mem_rdata == 0,  "rst_mid_mem_rdata",  bus.mem_rdata, 0);
    rst = 1'b0;
    mvalid[0] = 0; mdirty[0] = 0;  // 0x900 line was written back before the fill began
    model_reset();
    lat = 0;
    @(negedge clk);
    access(0, 32'h0000_0504, 0, 0, "reread_miss", rd);
    access(0, 32'h0000_0904, 0, 0, "reread_wb_line", rd);
    chk(rd == 32'h0BADF00D, "reread_wb_lit", rd, 32'h0BADF00D);
    access(0, 32'h0000_002C, 0, 0, "discarded_rd", rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
